// File: rtl/sonar_pkg.sv
// Shared sonar ranging constants and state encoding, used by both the sonar
// controller and the echo responder so timing has a single source of truth.
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_BURST   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } sonar_state_t;

    // Timing at a 100 MHz system clock
    localparam int unsigned TRIG_MIN_CYCLES        = 1000;     // 10 us
    localparam int unsigned BURST_DELAY_CYCLES     = 20000;    // 200 us
    localparam int unsigned ECHO_CYCLES_PER_CM     = 5800;     // 58 us/cm
    localparam int unsigned NO_ECHO_TIMEOUT_CYCLES = 3800000;  // 38 ms
    localparam int unsigned HOLDOFF_DEAD_CYCLES    = 6000000;  // 60 ms
    localparam int unsigned RANGE_MIN_CM           = 2;
    localparam int unsigned RANGE_MAX_CM           = 400;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sonar_echo_responder_trig_sync.sv
// Two-flop synchronizer for the asynchronous trig pin, plus rise/fall
// detection against a registered copy of the synchronized level.
module trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= trig;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/sonar_echo_responder.sv
// Ultrasonic ranger emulator: validates the trig pulse, waits the burst delay,
// then answers with an echo pulse whose width encodes the programmed distance.
module sonar_echo_responder
    import sonar_pkg::*;
#(
    parameter int unsigned MIN_TRIG_CYCLES = TRIG_MIN_CYCLES,
    parameter int unsigned BURST_CYCLES    = BURST_DELAY_CYCLES,
    parameter int unsigned CYCLES_PER_CM   = ECHO_CYCLES_PER_CM,
    parameter int unsigned MIN_CM          = RANGE_MIN_CM,
    parameter int unsigned MAX_CM          = RANGE_MAX_CM,
    parameter int unsigned NO_ECHO_CYCLES  = NO_ECHO_TIMEOUT_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_DEAD_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    input  logic       target_present,
    output logic       echo,
    output logic       busy,
    output logic       trig_short
);

    localparam int unsigned MAX_COUNT =
        max4(NO_ECHO_CYCLES, MAX_CM * CYCLES_PER_CM, HOLDOFF_CYCLES, BURST_CYCLES);
    localparam int unsigned CW = $clog2(MAX_COUNT + 1);

    localparam logic [8:0]    MIN_CM_W   = 9'(MIN_CM);
    localparam logic [8:0]    MAX_CM_W   = 9'(MAX_CM);
    localparam logic [CW-1:0] CPC_W      = CW'(CYCLES_PER_CM);
    localparam logic [CW-1:0] NO_ECHO_W  = CW'(NO_ECHO_CYCLES);
    localparam logic [CW-1:0] BURST_LOAD = CW'(BURST_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLDOFF_CYCLES - 1);
    // The rise cycle itself is not counted in TRIG_HI, so a pulse of exactly
    // MIN_TRIG_CYCLES at trig_s leaves the counter at MIN_TRIG_CYCLES-1.
    localparam logic [CW-1:0] ACCEPT_CNT = CW'(MIN_TRIG_CYCLES - 1);

    logic trig_level;
    logic trig_rise;
    logic trig_fall;

    trig_sync u_trig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .trig  (trig),
        .level (trig_level),
        .rise  (trig_rise),
        .fall  (trig_fall)
    );

    sonar_state_t  state;
    logic [CW-1:0] count;
    logic [CW-1:0] width_q;
    logic [8:0]    dist_clamped;
    logic [CW-1:0] width_next;

    always_comb begin
        dist_clamped = distance_cm;
        if (distance_cm < MIN_CM_W) begin
            dist_clamped = MIN_CM_W;
        end else if (distance_cm > MAX_CM_W) begin
            dist_clamped = MAX_CM_W;
        end
    end

    always_comb begin
        width_next = NO_ECHO_W;
        if (target_present) begin
            width_next = CW'(dist_clamped) * CPC_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            width_q    <= '0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            trig_short <= 1'b0;
        end else begin
            trig_short <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trig_rise) begin
                        state <= ST_TRIG_HI;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_TRIG_HI: begin
                    if (trig_fall) begin
                        if (count >= ACCEPT_CNT) begin
                            state   <= ST_BURST;
                            count   <= BURST_LOAD;
                            width_q <= width_next;
                        end else begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            trig_short <= 1'b1;
                        end
                    end else if (trig_level && (count != '1)) begin
                        count <= count + 1'b1;
                    end
                end
                ST_BURST: begin
                    if (count == '0) begin
                        state <= ST_ECHO;
                        echo  <= 1'b1;
                        count <= width_q - 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_ECHO: begin
                    if (count == '0) begin
                        state <= ST_HOLDOFF;
                        echo  <= 1'b0;
                        count <= HOLD_LOAD;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (count == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
